// File: rtl/vproj_pkg.sv
// Shared types and geometry for the V-projection weight path.
package vproj_pkg;

  localparam int VPROJ_ROWS   = 128;
  localparam int VPROJ_ADDR_W = 7;
  localparam int VPROJ_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdr_state_e;

  typedef logic [VPROJ_DATA_W-1:0] vproj_row_t;

endpackage

// File: rtl/vproj_row_fifo.sv
// First-word-fall-through row buffer; head reads as zero while empty.
module vproj_row_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vproj_row_reader.sv
// Issues SRAM row reads and streams returned rows to the MAC array over valid/ready.
// IDLE: wait start | RUN: issuing reads | DRAIN: all issued, emptying | DONE: done pulse
module vproj_row_reader
  import vproj_pkg::*;
#(
  parameter int READ_LAT   = 2,
  parameter int ADDR_W     = VPROJ_ADDR_W,
  parameter int DATA_W     = VPROJ_DATA_W,
  parameter int FIFO_DEPTH = READ_LAT + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              abort,
  input  logic              init_busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int TAG_N = 1 + READ_LAT;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = $clog2(FIFO_DEPTH + TAG_N + 1);

  rdr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [ADDR_W:0]   num_q, issued_q;
  logic [TAG_N-1:0]  tag_vld_q, tag_last_q;
  logic              start_acc, issue, issue_last, credit_ok, pop;
  logic [ADDR_W-1:0] issue_addr;
  logic [CR_W-1:0]   inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [DATA_W:0]   fifo_rdata;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < TAG_N; i++) inflight = inflight + CR_W'(tag_vld_q[i]);
  end

  // Rows already in the wrapper pipe count against buffer space: the pipe cannot stall.
  assign credit_ok  = ~fifo_full & ((CR_W'(fifo_count) + inflight) < CR_W'(FIFO_DEPTH));
  assign start_acc  = (state_q == IDLE) & start & ~abort;
  assign issue      = (state_q == RUN) & ~init_busy & ~abort & (issued_q != num_q) & credit_ok;
  assign issue_last = issue & ((issued_q + (ADDR_W+1)'(1)) == num_q);
  assign issue_addr = base_q + issued_q[ADDR_W-1:0];
  assign rd_addr    = issue ? issue_addr : addr_q;

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_rdata[DATA_W-1:0];
  assign m_last  = fifo_rdata[DATA_W];
  assign pop     = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = (num_rows == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (issued_q == num_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop & m_last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      addr_q <= rd_addr;
      if (start_acc) begin
        base_q   <= base_addr;
        num_q    <= num_rows;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
      if (abort) begin
        tag_vld_q  <= '0;
        tag_last_q <= '0;
      end else begin
        tag_vld_q  <= {tag_vld_q[TAG_N-2:0], issue};
        tag_last_q <= {tag_last_q[TAG_N-2:0], issue_last};
      end
    end
  end

  vproj_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort),
    .push_i  (tag_vld_q[TAG_N-1]),
    .wdata_i ({tag_last_q[TAG_N-1], rd_dout}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule
